// File: rtl/twf_cmul_m1.sv
// twf_cmul_m1: streaming complex multiplier on the stage-1 twiddle ROM side.
// Drives the twiddle address for each input sample, lines the ROM's registered
// output up with the delayed sample, then multiplies, rounds and emits the
// rotated sample three cycles after it arrived.
module twf_cmul_m1 #(
    parameter int DW = 14,   // input component width; output is DW+1
    parameter int TW = 9,    // twiddle width, Q1.7 (+128 = 1.0)
    parameter int AW = 6     // twiddle address width
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 din_valid,
    input  logic                 din_sof,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    output logic [AW-1:0]        twf_addr,
    input  logic signed [TW-1:0] twf_re,
    input  logic signed [TW-1:0] twf_im,
    output logic                 dout_valid,
    output logic                 dout_sof,
    output logic signed [DW:0]   dout_re,
    output logic signed [DW:0]   dout_im
);

    // Product width and the width of the sum/difference of two products.
    localparam int PW  = DW + TW;
    localparam int SW  = DW + TW + 1;
    // Twiddles carry TW-2 fraction bits; round half up before dropping them.
    localparam int SH  = TW - 2;
    localparam int RND = 1 << (SH - 1);

    // ------------------------------------------------------------------
    // Address counter
    // ------------------------------------------------------------------
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // A qualified sof forces address 0; otherwise the running count is used.
    // The next count follows the address actually consumed so that a resync
    // continues from 1 on the following sample.
    always_comb begin
        twf_addr = (din_valid && din_sof) ? '0 : cnt_q;
        cnt_d    = din_valid ? (twf_addr + AW'(1)) : cnt_q;
    end

    // Counter register; wraps naturally at 2^AW.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: register the sample. The ROM registers the address on the same
    // edge, so in this cycle twf_re/twf_im already belong to this sample.
    // ------------------------------------------------------------------
    logic                 s1_valid_q;
    logic                 s1_sof_q;
    logic signed [DW-1:0] s1_re_q;
    logic signed [DW-1:0] s1_im_q;

    // Sample delay stage matching the ROM read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
        end else begin
            s1_valid_q <= din_valid;
            s1_sof_q   <= din_valid & din_sof;
            s1_re_q    <= din_re;
            s1_im_q    <= din_im;
        end
    end

    // ------------------------------------------------------------------
    // S2: four partial products re*wr, im*wi, re*wi, im*wr.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] op_a [4];
    logic signed [TW-1:0] op_b [4];
    logic signed [PW-1:0] prod_d [4];
    logic signed [PW-1:0] prod_q [4];
    logic                 s2_valid_q;
    logic                 s2_sof_q;

    // Operand routing for the four multipliers.
    always_comb begin
        op_a[0] = s1_re_q;  op_b[0] = twf_re;
        op_a[1] = s1_im_q;  op_b[1] = twf_im;
        op_a[2] = s1_re_q;  op_b[2] = twf_im;
        op_a[3] = s1_im_q;  op_b[3] = twf_re;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mul
            // Both operands sign-extended to full product width first.
            assign prod_d[gi] = PW'(op_a[gi]) * PW'(op_b[gi]);

            // Product pipeline register.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    prod_q[gi] <= '0;
                end else begin
                    prod_q[gi] <= prod_d[gi];
                end
            end
        end
    endgenerate

    // Control bits follow the products.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: combine, round, and register the output.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] pr;
    logic signed [SW-1:0] pi;
    logic signed [SW-1:0] rnd_re;
    logic signed [SW-1:0] rnd_im;
    logic signed [DW:0]   dout_re_d;
    logic signed [DW:0]   dout_im_d;

    // Complex combine plus round-half-up. Taking bits [SH+DW:SH] is the
    // arithmetic shift by SH truncated to DW+1 bits; the twiddle magnitude
    // bound guarantees the discarded upper bits are pure sign.
    always_comb begin
        pr        = SW'(prod_q[0]) - SW'(prod_q[1]);
        pi        = SW'(prod_q[2]) + SW'(prod_q[3]);
        rnd_re    = pr + SW'(RND);
        rnd_im    = pi + SW'(RND);
        dout_re_d = rnd_re[SH+DW:SH];
        dout_im_d = rnd_im[SH+DW:SH];
    end

    // Bits dropped by the rounding shift and the guaranteed-sign top bits.
    logic unused_round_bits;
    assign unused_round_bits = ^{rnd_re[SW-1:SH+DW+1], rnd_re[SH-1:0],
                                 rnd_im[SW-1:SH+DW+1], rnd_im[SH-1:0]};

    logic                 dout_valid_q;
    logic                 dout_sof_q;
    logic signed [DW:0]   dout_re_q;
    logic signed [DW:0]   dout_im_q;

    // Output register: data only moves on valid, so it holds through gaps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_re_q    <= '0;
            dout_im_q    <= '0;
        end else begin
            dout_valid_q <= s2_valid_q;
            dout_sof_q   <= s2_valid_q & s2_sof_q;
            if (s2_valid_q) begin
                dout_re_q <= dout_re_d;
                dout_im_q <= dout_im_d;
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;

endmodule

// File: tb/tb_twf_cmul_m1.sv
// Testbench for twf_cmul_m1: local twiddle ROM model, address model and an
// expected-result queue checked when the DUT presents output.
module tb_twf_cmul_m1;

    localparam int DW = 14;
    localparam int TW = 9;
    localparam int AW = 6;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 din_valid = 1'b0;
    logic                 din_sof = 1'b0;
    logic signed [DW-1:0] din_re = '0;
    logic signed [DW-1:0] din_im = '0;
    logic [AW-1:0]        twf_addr;
    logic signed [TW-1:0] twf_re = '0;
    logic signed [TW-1:0] twf_im = '0;
    logic                 dout_valid;
    logic                 dout_sof;
    logic signed [DW:0]   dout_re;
    logic signed [DW:0]   dout_im;

    twf_cmul_m1 #(.DW(DW), .TW(TW), .AW(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_re     (din_re),
        .din_im     (din_im),
        .twf_addr   (twf_addr),
        .twf_re     (twf_re),
        .twf_im     (twf_im),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_re    (dout_re),
        .dout_im    (dout_im)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Twiddle table: W = exp(-j*pi*k/8) scaled by 128, k = (a>>3)*(a&7) mod 16.
    int cos16 [16] = '{128, 118, 91, 49, 0, -49, -91, -118,
                       -128, -118, -91, -49, 0, 49, 91, 118};
    int msin16 [16] = '{0, -49, -91, -118, -128, -118, -91, -49,
                        0, 49, 91, 118, 128, 118, 91, 49};

    function automatic int rom_k(int a);
        return ((a >> 3) * (a & 7)) & 15;
    endfunction

    // ROM model: registered output, one cycle latency.
    always @(posedge clk) begin
        twf_re <= TW'(cos16[rom_k(int'(twf_addr))]);
        twf_im <= TW'(msin16[rom_k(int'(twf_addr))]);
    end

    typedef struct {
        int re;
        int im;
        bit sof;
        int cyc;
    } exp_t;

    exp_t sb [$];
    int   mcnt    = 0;
    int   last_re = 0;
    int   last_im = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int re, input int im, input int a,
                                  output int ore, output int oim);
        longint wr, wi, pr, pi;
        wr  = cos16[rom_k(a)];
        wi  = msin16[rom_k(a)];
        pr  = longint'(re) * wr - longint'(im) * wi;
        pi  = longint'(re) * wi + longint'(im) * wr;
        ore = int'((pr + 64) >>> 7);
        oim = int'((pi + 64) >>> 7);
    endfunction

    // One input cycle. kn=1 supplies a fixed expected result instead of the model.
    task automatic drive(input bit v, input bit s, input int re, input int im,
                         input bit kn, input int kre, input int kim);
        int   ea;
        exp_t e;
        din_valid = v;
        din_sof   = s;
        din_re    = re[DW-1:0];
        din_im    = im[DW-1:0];
        ea = (v && s) ? 0 : mcnt;
        #1;
        chk("twf_addr", longint'(twf_addr), longint'(ea));
        if (v) begin
            if (kn) begin
                e.re = kre;
                e.im = kim;
            end else begin
                model(re, im, ea, e.re, e.im);
            end
            e.sof = s;
            e.cyc = cyc;
            sb.push_back(e);
            mcnt = (ea + 1) % 64;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(16383)) - 8192;
    endfunction

    task automatic rnd_samples(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b0, 0, 0);
    endtask

    // Reset with random inputs; outputs and address must sit at zero.
    task automatic do_reset(input int n);
        rstn = 1'b0;
        sb.delete();
        mcnt = 0;
        for (int i = 0; i < n; i++) begin
            din_valid = 1'($urandom);
            din_sof   = 1'($urandom);
            din_re    = DW'($urandom);
            din_im    = DW'($urandom);
            #1;
            chk("rst_valid", longint'(dout_valid), 0);
            chk("rst_sof", longint'(dout_sof), 0);
            chk("rst_re", longint'(dout_re), 0);
            chk("rst_im", longint'(dout_im), 0);
            chk("rst_addr", longint'(twf_addr), 0);
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            last_re = 0;
            last_im = 0;
        end else if (dout_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dout_re", longint'(dout_re), longint'(e.re));
                chk("dout_im", longint'(dout_im), longint'(e.im));
                chk("dout_sof", longint'(dout_sof), longint'(e.sof));
                chk("latency", longint'(cyc - e.cyc), 3);
                last_re = e.re;
                last_im = e.im;
            end
        end else begin
            chk("hold_re", longint'(dout_re), longint'(last_re));
            chk("hold_im", longint'(dout_im), longint'(last_im));
            chk("bubble_sof", longint'(dout_sof), 0);
            if (sb.size() > 0 && (cyc - sb[0].cyc) >= 3) begin
                chk("missed_output", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        // Reset, then a full address sweep plus the wrap
        do_reset(4);
        for (int i = 0; i < 64; i++) begin
            if (i == 5)       drive(1'b1, 1'b0, -8192, -8192, 1'b0, 0, 0);
            else if (i == 21) drive(1'b1, 1'b0, 8191, -8192, 1'b0, 0, 0);
            else if (i == 37) drive(1'b1, 1'b0, 8191, 8191, 1'b0, 0, 0);
            else              rnd_samples(1);
        end
        rnd_samples(1);

        // W[12] = (0,-128): (100,50) -> (50,-100)
        drive(1'b1, 1'b1, rnd_s(), rnd_s(), 1'b0, 0, 0);
        rnd_samples(11);
        drive(1'b1, 1'b0, 100, 50, 1'b1, 50, -100);

        // W[10] = (91,-91) and W[14] = (-91,-91)
        drive(1'b1, 1'b1, rnd_s(), rnd_s(), 1'b0, 0, 0);
        rnd_samples(9);
        drive(1'b1, 1'b0, 128, 0, 1'b1, 91, -91);
        rnd_samples(3);
        drive(1'b1, 1'b0, -8192, -8192, 1'b1, 0, 11648);
        idle(4);

        // Bubbles 1,0,0,1,1 starting at address 8
        drive(1'b1, 1'b1, rnd_s(), rnd_s(), 1'b0, 0, 0);
        rnd_samples(7);
        drive(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b0, 0, 0);
        drive(1'b0, 1'b0, rnd_s(), rnd_s(), 1'b0, 0, 0);
        drive(1'b0, 1'b1, rnd_s(), rnd_s(), 1'b0, 0, 0);
        drive(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b0, 0, 0);
        drive(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b0, 0, 0);
        idle(5);

        // Mid-frame sof resync after 20 samples
        rnd_samples(20);
        drive(1'b1, 1'b1, rnd_s(), rnd_s(), 1'b0, 0, 0);
        drive(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b0, 0, 0);
        rnd_samples(2);
        idle(5);

        // Reset with three samples in flight
        rnd_samples(3);
        do_reset(2);
        idle(4);
        drive(1'b1, 1'b0, 300, -200, 1'b0, 0, 0);
        rnd_samples(2);
        idle(6);

        chk("sb_empty", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twf_cmul_m1.md
Name: twf_cmul_m1

Overview:
- Streaming complex multiplier that is the consumer side of the stage-1 twiddle ROM (twf_m1).
- Generates the 6-bit twiddle address for each incoming sample and drives it to the ROM.
- Aligns the ROM's registered twiddle output with the delayed sample, then multiplies, rounds and outputs the rotated sample.
- Sits between the stage-1 butterfly output and the CBFP scaling block in the 512-point FFT datapath.

Parameters:
- DW, 14: signed width of input real/imag components; output components are DW+1 bits.
- TW, 9: signed twiddle width (Q1.7, +128 = 1.0); fixed by the ROM format.
- AW, 6: twiddle address width; the address wraps modulo 2^AW.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- din_valid  in  1  input sample valid
- din_sof  in  1  first sample of frame; qualified by din_valid
- din_re  in  DW  signed input real
- din_im  in  DW  signed input imag
- twf_addr  out  AW  address to the twiddle ROM (combinational)
- twf_re  in  TW  ROM real output; registered in ROM, 1-cycle latency
- twf_im  in  TW  ROM imag output; registered in ROM, 1-cycle latency
- dout_valid  out  1  output sample valid
- dout_sof  out  1  frame start, aligned with dout_valid
- dout_re  out  DW+1  signed rotated real
- dout_im  out  DW+1  signed rotated imag

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low (rstn). On reset all registers clear: cnt=0, all pipeline valid/sof bits=0, data registers=0. So dout_valid=0, dout_sof=0, dout_re=0, dout_im=0.
- Address counter: cnt, AW bits.
  - twf_addr = (din_valid & din_sof) ? 0 : cnt.
  - On din_valid: cnt <= twf_addr+1, wrapping 63->0 with no flag.
  - With din_valid=0, cnt holds.
  - din_sof without din_valid is ignored.
  - sof mid-frame forces a resync to 0; sof wins over the counter value.
- Stage S1 (cycle +1):
  - Register din_re/din_im/din_valid/din_sof.
  - The ROM output in this cycle equals W[twf_addr of the previous cycle], so it is already aligned.
  - twf_addr is driven every cycle, including invalid cycles; ROM data on invalid cycles is don't-care.
- Stage S2 (cycle +2): register the four products re*wr, im*wi, re*wi, im*wr. Each is DW+TW bits signed.
- Stage S3 (cycle +3):
  - pr = re*wr - im*wi; pi = re*wi + im*wr (DW+TW+1 bits).
  - Output = (p + 64) >>> 7, arithmetic shift, round-half-up, truncated to DW+1 bits.
  - No saturation: |w| ≤ 128 with |wr|+|wi| ≤ 182, so the result always fits in DW+1 bits.
- Latency: fixed 3 cycles from din_valid to dout_valid. Throughput 1 sample/cycle. Gaps propagate unchanged.
- Output hold: dout_re/dout_im update only when the S3 valid is 1; otherwise they hold their previous value. dout_valid and dout_sof are 0 in bubbles.
- No backpressure.
- Reset asserted mid-stream: in-flight samples are discarded. After release the first valid sample uses addr 0 unless a sof re-aligns it.

Test Plan:
1. Reset: hold rstn=0 with random inputs -> dout_valid=0, dout_re=0, dout_im=0, twf_addr=0. Release, then 64 consecutive valid samples -> twf_addr steps 0..63, then wraps to 0 on the 65th.
2. Sample idx 12 (W=(0,-128)), input (100,50) -> 3 cycles later dout=(50,-100).
3. Sample idx 10 (W=(91,-91)), input (128,0) -> dout=(91,-91). Input (-8192,-8192) at idx 14 (W=(-91,-91)) -> dout=(0,11648).
4. Bubbles: valid pattern 1,0,0,1,1 starting at addr 8 -> addresses consumed 8,9,10. dout_valid pattern identical, delayed 3 cycles; data held during gaps.
5. sof resync: after 20 valid samples, assert din_sof -> twf_addr=0 that cycle, next valid uses addr 1, dout_sof pulses exactly 3 cycles later.
6. Reset mid-stream with 3 samples in flight -> no dout_valid after reset. First post-reset sample uses addr 0.
